// File: rtl/bcd_pkg.sv
// Shared types and helpers for the packed-BCD datapath.
package bcd_pkg;

  localparam int BCD_ROWS = 3;

  typedef logic [7:0] bcd_byte_t;

  function automatic bcd_byte_t nines_byte(input bcd_byte_t d);
    return {4'd9 - d[7:4], 4'd9 - d[3:0]};
  endfunction

  function automatic logic bcd_nibble_invalid(input logic [3:0] n);
    return n > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_byte_add.sv
// Combinational two-digit BCD adder with decimal carry in/out.
module bcd_byte_add
  import bcd_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] o,
  output logic       co
);

  logic [4:0] lo;
  logic [4:0] hi;
  logic       lo_c;

  always_comb begin
    lo   = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, ci};
    lo_c = lo > 5'd9;
    hi   = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0, lo_c};
    co   = hi > 5'd9;
    o[3:0] = lo_c ? lo[3:0] + 4'd6 : lo[3:0];
    o[7:4] = co   ? hi[3:0] + 4'd6 : hi[3:0];
  end

endmodule

// File: rtl/bcd_addsub_pipe.sv
// Three-row pipelined packed-BCD adder/subtractor: per-byte sums, byte-carry
// resolution, then a per-byte increment into the output register.
module bcd_addsub_pipe
  import bcd_pkg::*;
#(
  parameter int N   = 33,
  parameter int LAT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         ld,
  input  logic         sub,
  input  logic [N*8-1:0] a,
  input  logic [N*8-1:0] b,
  input  logic         ci,
  output logic [N*8-1:0] o,
  output logic         co,
  output logic         inv,
  output logic         vo
);

  if (LAT != BCD_ROWS) begin : g_lat_chk
    $error("bcd_addsub_pipe: LAT must be %0d", BCD_ROWS);
  end
  if (N < 1 || N > 64) begin : g_n_chk
    $error("bcd_addsub_pipe: N must be in 1..64");
  end

  logic [N*8-1:0] s0_d, s0_q, s1_q, s2_d;
  logic [N-1:0]   c0_d, c0_q, cin_d, cin_q, c2;
  logic           inv_d, inv0_q, inv1_q;
  logic           v0_q, v1_q;
  logic           cg_q;
  logic           run;

  for (genvar g = 0; g < N; g++) begin : g_byte
    bcd_byte_t bb;
    assign bb = sub ? nines_byte(b[g*8 +: 8]) : b[g*8 +: 8];

    bcd_byte_add u_row0 (
      .a  (a[g*8 +: 8]),
      .b  (bb),
      .ci ((g == 0) ? ci : 1'b0),
      .o  (s0_d[g*8 +: 8]),
      .co (c0_d[g])
    );

    // b tied to zero: reduces to a carry-in increment of the row-0 byte sum.
    bcd_byte_add u_row2 (
      .a  (s1_q[g*8 +: 8]),
      .b  (8'h00),
      .ci (cin_q[g]),
      .o  (s2_d[g*8 +: 8]),
      .co (c2[g])
    );
  end

  always_comb begin
    inv_d = 1'b0;
    for (int i = 0; i < 2*N; i++) begin
      inv_d = inv_d | bcd_nibble_invalid(a[i*4 +: 4]) | bcd_nibble_invalid(b[i*4 +: 4]);
    end
  end

  // A byte summing to 99 passes an incoming carry on, so runs of 99 ripple.
  always_comb begin
    cin_d = '0;
    run   = 1'b0;
    for (int g = 1; g < N; g++) begin
      run      = c0_q[g-1] | ((s0_q[(g-1)*8 +: 8] == 8'h99) & run);
      cin_d[g] = run;
    end
  end

  logic unused_c2;
  assign unused_c2 = ^c2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q   <= '0;
      c0_q   <= '0;
      v0_q   <= 1'b0;
      inv0_q <= 1'b0;
      s1_q   <= '0;
      cin_q  <= '0;
      cg_q   <= 1'b0;
      v1_q   <= 1'b0;
      inv1_q <= 1'b0;
      o      <= '0;
      co     <= 1'b0;
      inv    <= 1'b0;
      vo     <= 1'b0;
    end else if (ce) begin
      s0_q   <= s0_d;
      c0_q   <= c0_d;
      v0_q   <= ld;
      inv0_q <= inv_d;
      s1_q   <= s0_q;
      cin_q  <= cin_d;
      cg_q   <= c0_q[N-1];
      v1_q   <= v0_q;
      inv1_q <= inv0_q;
      vo     <= v1_q;
      if (v1_q) begin
        o   <= s2_d;
        co  <= cg_q | c2[N-1];
        inv <= inv1_q;
      end
    end
  end

endmodule
